me_block_loader: RTL and testbench

- Feeder for the motion-estimation core.
- Accepts a serial stream of 64-bit pixel rows: 16 current-block rows, then 16 previous/search rows.
- Assembles them into a double-buffered row bank and presents one complete block pair on parallel row buses, with a valid/ready handshake toward the core-side consumer.
- Sits between the frame memory read path and the SAD/motion-vector core, so the core sees a stable 32-row operand set while the next set is being filled.

---
 rtl/me_pkg.sv | 16 +
 rtl/me_row_bank.sv | 32 +++
 rtl/me_block_loader.sv | 135 +++++++++++++
 tb/tb_me_block_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared sizing and types for the motion-estimation block loader.
package me_pkg;

  localparam int ROW_W     = 64;
  localparam int ROWS      = 16;
  localparam int BLK_BEATS = 2 * ROWS;
  localparam int CNT_W     = 5;

  typedef logic [ROW_W-1:0] rowWord_t;

  // True when the beat counter sits on the final beat of a block pair.
  function automatic logic isLastBeat(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(BLK_BEATS - 1);
  endfunction

endpackage

// File: rtl/me_row_bank.sv
// One storage bank holding a full block pair: BLK_BEATS row words.
// Words 0..ROWS-1 are the current rows, ROWS..BLK_BEATS-1 the previous rows.
// Contents are deliberately not reset; the loader never presents a bank
// until it has been completely written.
module me_row_bank
  import me_pkg::*;
(
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [CNT_W-1:0]           i_idx,
  input  rowWord_t                   i_data,
  output logic [BLK_BEATS*ROW_W-1:0] o_words
);

  rowWord_t r_mem [BLK_BEATS];

  // Single write port: store the incoming row at the beat index.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  // Flatten the whole bank so word k lands at bits [k*ROW_W +: ROW_W].
  always_comb begin
    o_words = '0;
    for (int k = 0; k < BLK_BEATS; k++) begin
      o_words[k*ROW_W +: ROW_W] = r_mem[k];
    end
  end

endmodule

// File: rtl/me_block_loader.sv
// Double-buffered row loader feeding the SAD / motion-vector core.
// A serial stream of row words fills one bank while the core reads a stable
// block pair out of the other bank.
// Optional build macro ME_BLOCK_LOADER_SOF_EN adds a start-of-frame input
// (s_sof) that forces resynchronisation, plus a one-cycle sync_err pulse
// whenever a partial fill had to be thrown away.
module me_block_loader
  import me_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  rowWord_t              s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ROWS*ROW_W-1:0] crt_rows,
  output logic [ROWS*ROW_W-1:0] pre_rows
`ifdef ME_BLOCK_LOADER_SOF_EN
  ,
  input  logic                  s_sof,
  output logic                  sync_err
`endif
);

  logic                       r_wrBank;
  logic                       r_rdBank;
  logic [1:0]                 r_full;
  logic [CNT_W-1:0]           r_cnt;

  logic                       w_accept;
  logic                       w_drain;
  logic                       w_sof;
  logic                       w_last;
  logic [CNT_W-1:0]           w_idx;
  logic [1:0]                 w_fullNext;
  logic                       w_we0;
  logic                       w_we1;
  logic [BLK_BEATS*ROW_W-1:0] w_bank0Words;
  logic [BLK_BEATS*ROW_W-1:0] w_bank1Words;
  logic [BLK_BEATS*ROW_W-1:0] w_rdWords;

`ifdef ME_BLOCK_LOADER_SOF_EN
  logic r_syncErr;
  assign w_sof    = s_sof;
  assign sync_err = r_syncErr;
`else
  assign w_sof = 1'b0;
`endif

  // Ready depends only on registered state so upstream sees no s_valid loop.
  assign s_ready  = !r_full[r_wrBank];
  assign m_valid  = r_full[r_rdBank];
  assign w_accept = s_valid && s_ready;
  assign w_drain  = m_valid && m_ready;

  // A start-of-frame beat always lands in slot 0; otherwise the counter picks the slot.
  assign w_idx  = w_sof ? '0 : r_cnt;
  assign w_last = w_accept && !w_sof && isLastBeat(r_cnt);

  assign w_we0 = w_accept && (r_wrBank == 1'b0);
  assign w_we1 = w_accept && (r_wrBank == 1'b1);

  me_row_bank u_bank0 (
    .clk     (clk),
    .i_we    (w_we0),
    .i_idx   (w_idx),
    .i_data  (s_data),
    .o_words (w_bank0Words)
  );

  me_row_bank u_bank1 (
    .clk     (clk),
    .i_we    (w_we1),
    .i_idx   (w_idx),
    .i_data  (s_data),
    .o_words (w_bank1Words)
  );

  // Fill completion and drain can coincide; they always touch different banks.
  always_comb begin
    w_fullNext = r_full;
    if (w_last) begin
      w_fullNext[r_wrBank] = 1'b1;
    end
    if (w_drain) begin
      w_fullNext[r_rdBank] = 1'b0;
    end
  end

  // Bank pointers, full flags and the beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_wrBank <= 1'b0;
      r_rdBank <= 1'b0;
      r_full   <= 2'b00;
    end else begin
      if (w_accept) begin
        if (w_sof) begin
          r_cnt <= CNT_W'(1);
        end else if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_last) begin
        r_wrBank <= ~r_wrBank;
      end
      if (w_drain) begin
        r_rdBank <= ~r_rdBank;
      end
      r_full <= w_fullNext;
    end
  end

`ifdef ME_BLOCK_LOADER_SOF_EN
  // Flag a resync that discarded a partially filled block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_syncErr <= 1'b0;
    end else begin
      r_syncErr <= w_accept && w_sof && (r_cnt != '0);
    end
  end
`endif

  assign w_rdWords = r_rdBank ? w_bank1Words : w_bank0Words;

  // Present the read bank only while it holds a valid block pair.
  assign crt_rows = m_valid ? w_rdWords[ROWS*ROW_W-1:0]              : '0;
  assign pre_rows = m_valid ? w_rdWords[BLK_BEATS*ROW_W-1:ROWS*ROW_W] : '0;

endmodule

// File: tb/tb_me_block_loader.sv
// Directed self-checking bench for me_block_loader.
// Build with ME_BLOCK_LOADER_SOF_EN defined to also exercise the resync path.
module tb_me_block_loader;
  import me_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic [ROW_W-1:0]      s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ROWS*ROW_W-1:0] crt_rows;
  logic [ROWS*ROW_W-1:0] pre_rows;
  logic                  s_sof;
  logic                  sync_err;

  int checkCount  = 0;
  int errorCount  = 0;
  int stallCycles = 0;

  // Streaming monitor state.
  logic        streamOn = 1'b0;
  logic [63:0] expStream [320];
  int          blkOut    = 0;
  int          streamBad = 0;
  int          zeroBad   = 0;
  int          sReadyLow = 0;
  int          errCycles = 0;

  me_block_loader dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .crt_rows (crt_rows),
    .pre_rows (pre_rows)
`ifdef ME_BLOCK_LOADER_SOF_EN
    ,
    .s_sof    (s_sof),
    .sync_err (sync_err)
`endif
  );

`ifndef ME_BLOCK_LOADER_SOF_EN
  assign sync_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // Hard stop in case something wedges the bench.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] crtRow(input int k);
    return crt_rows[k*ROW_W +: ROW_W];
  endfunction

  function automatic logic [63:0] preRow(input int k);
    return pre_rows[k*ROW_W +: ROW_W];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Offer one beat and wait (bounded) until it is taken.
  task automatic applyStimulus(input logic [63:0] data, input logic sof);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_sof   = sof;
    while (!s_ready && guard < 200) begin
      tick();
      guard++;
      stallCycles++;
    end
    if (!s_ready) begin
      checkOutput("beat_timeout", 64'd0, 64'd1);
    end
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Count rows of the presented block that differ from base+index.
  task automatic checkBlock(input string tag, input int base);
    int bad = 0;
    for (int k = 0; k < ROWS; k++) begin
      if (crtRow(k) !== 64'(base + k))        bad++;
      if (preRow(k) !== 64'(base + ROWS + k)) bad++;
    end
    checkOutput(tag, 64'(bad), 64'd0);
  endtask

  task automatic doReset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Sample away from the driving edge: block contents, zeroing and ready.
  always @(negedge clk) begin
    if (sync_err) errCycles++;
    if (streamOn) begin
      if (m_valid) begin
        if (blkOut < 10) begin
          for (int k = 0; k < ROWS; k++) begin
            if (crt_rows[k*ROW_W +: ROW_W] !== expStream[blkOut*BLK_BEATS + k])        streamBad++;
            if (pre_rows[k*ROW_W +: ROW_W] !== expStream[blkOut*BLK_BEATS + ROWS + k]) streamBad++;
          end
        end else begin
          streamBad++;
        end
        blkOut++;
      end else if (crt_rows !== '0 || pre_rows !== '0) begin
        zeroBad++;
      end
      if (!s_ready) sReadyLow++;
    end
  end

  initial begin
    logic [ROWS*ROW_W-1:0] snapCrt;
    logic [ROWS*ROW_W-1:0] snapPre;
    int holdBad;
    int aaBad;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    m_ready = 1'b0;
    doReset();

    // Reset state.
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
    checkOutput("rst_crt_zero", 64'(|crt_rows), 64'd0);
    checkOutput("rst_pre_zero", 64'(|pre_rows), 64'd0);

    // Basic fill: beat index as data.
    for (int i = 0; i < 31; i++) applyStimulus(64'(i), 1'b0);
    checkOutput("basic_pre_valid", 64'(m_valid), 64'd0);
    applyStimulus(64'd31, 1'b0);
    checkOutput("basic_m_valid", 64'(m_valid), 64'd1);
    checkBlock("basic_blk", 0);
    checkOutput("basic_s_ready", 64'(s_ready), 64'd1);

    // Backpressure with output hold while bank 1 fills.
    snapCrt = crt_rows;
    snapPre = pre_rows;
    holdBad = 0;
    for (int i = 32; i < 64; i++) begin
      applyStimulus(64'(i), 1'b0);
      if (crt_rows !== snapCrt || pre_rows !== snapPre || !m_valid) holdBad++;
    end
    checkOutput("hold_stable", 64'(holdBad), 64'd0);
    checkOutput("bp_s_ready_low", 64'(s_ready), 64'd0);
    s_valid = 1'b1;
    s_data  = 64'd64;
    repeat (3) tick();
    checkOutput("bp_stall", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    checkBlock("bp_blk0", 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("bp_m_valid_b1", 64'(m_valid), 64'd1);
    checkBlock("bp_blk1", 32);
    checkOutput("bp_s_ready_back", 64'(s_ready), 64'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("drain_m_valid", 64'(m_valid), 64'd0);
    checkOutput("drain_crt_zero", 64'(|crt_rows), 64'd0);
    checkOutput("drain_pre_zero", 64'(|pre_rows), 64'd0);

    // Reset mid-fill, then a uniform 0xAA block.
    for (int i = 0; i < 10; i++) applyStimulus(64'h1000 + 64'(i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_m_valid", 64'(m_valid), 64'd0);
    for (int i = 0; i < 31; i++) applyStimulus({8{8'hAA}}, 1'b0);
    checkOutput("midrst_pre_valid", 64'(m_valid), 64'd0);
    applyStimulus({8{8'hAA}}, 1'b0);
    checkOutput("midrst_m_valid_up", 64'(m_valid), 64'd1);
    aaBad = 0;
    for (int k = 0; k < ROWS; k++) begin
      if (crtRow(k) !== {8{8'hAA}}) aaBad++;
      if (preRow(k) !== {8{8'hAA}}) aaBad++;
    end
    checkOutput("midrst_rows_aa", 64'(aaBad), 64'd0);

    // Streaming: ten blocks back to back with the consumer always ready.
    doReset();
    for (int i = 0; i < 320; i++) expStream[i] = {$urandom, $urandom};
    m_ready     = 1'b1;
    stallCycles = 0;
    streamOn    = 1'b1;
    for (int i = 0; i < 320; i++) applyStimulus(expStream[i], 1'b0);
    tick();
    tick();
    streamOn = 1'b0;
    m_ready  = 1'b0;
    checkOutput("stream_stalls", 64'(stallCycles), 64'd0);
    checkOutput("stream_ready_low", 64'(sReadyLow), 64'd0);
    checkOutput("stream_blocks", 64'(blkOut), 64'd10);
    checkOutput("stream_data", 64'(streamBad), 64'd0);
    checkOutput("stream_zero", 64'(zeroBad), 64'd0);

`ifdef ME_BLOCK_LOADER_SOF_EN
    // Start-of-frame resync after a 7-beat partial fill.
    doReset();
    errCycles = 0;
    for (int i = 0; i < 7; i++) applyStimulus(64'h100 + 64'(i), 1'b0);
    checkOutput("sof_no_err_yet", 64'(sync_err), 64'd0);
    applyStimulus(64'h5, 1'b1);
    checkOutput("sof_err_pulse", 64'(sync_err), 64'd1);
    for (int i = 0; i < 31; i++) applyStimulus(64'h200 + 64'(i), 1'b0);
    checkOutput("sof_err_cycles", 64'(errCycles), 64'd1);
    checkOutput("sof_m_valid", 64'(m_valid), 64'd1);
    checkOutput("sof_crt_row0", crtRow(0), 64'h5);
    checkOutput("sof_crt_row1", crtRow(1), 64'h200);
    checkOutput("sof_pre_row15", preRow(15), 64'h21E);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
